// File: rtl/qdec_pkg.sv
// qdec_pkg: shared FSM states, Gray phase constants and the step-direction
// helper used by the quadrature decoder and its channel filters.
package qdec_pkg;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    ALIGN = 2'd1,
    TRACK = 2'd2
  } qdec_state_t;

  // Filtered phase values {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Cycles spent in WARM while the two-flop synchronizers fill
  localparam int WARM_CYCLES = 2;

  // Next phase when the encoder turns one step in the up direction
  function automatic logic [1:0] qdec_next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // Returns {legal, up}: legal when exactly one channel changed, up when the
  // change follows the up sequence. up is forced low for illegal changes.
  function automatic logic [1:0] qdec_dir(input logic [1:0] old_ph,
                                          input logic [1:0] new_ph);
    logic legal;
    logic up;
    legal = ^(old_ph ^ new_ph);
    up    = legal && (new_ph == qdec_next_up(old_ph));
    return {legal, up};
  endfunction

endpackage

// File: rtl/qdec_chan_filter.sv
// qdec_chan_filter: per-channel two-flop synchronizer plus optional glitch
// filter, enabled by defining QDEC_FILTER_EN. With the filter, dout only
// follows the synchronized value after it has differed for FILT_LEN cycles.
module qdec_chan_filter
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic sync1;
  logic sync2;

  // Out-of-range FILT_LEN values (legal range 1..15) leave this marker
  // block elaborated so they are easy to spot in a hierarchy dump.
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_filt_len_out_of_range
  end

  // Two-flop synchronizer for the asynchronous encoder pin
  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam logic [3:0] FILT_MAX   = 4'(FILT_LEN);
  localparam logic [1:0] BOOT_EDGES = 2'(WARM_CYCLES + 1);

  logic [1:0] boot_cnt;
  logic       booting;
  logic [3:0] cnt;
  logic       filt;

  // The top loads its phase during ALIGN, so until the ALIGN edge the
  // synchronized value is passed straight through and then seeds the filter.
  assign booting = (boot_cnt != BOOT_EDGES);
  assign dout    = booting ? sync2 : filt;

  // Startup edge counter that tracks the top's WARM/ALIGN window
  always_ff @(posedge clk) begin
    if (!clr) begin
      boot_cnt <= 2'd0;
    end else if (booting) begin
      boot_cnt <= boot_cnt + 2'd1;
    end
  end

  // Glitch filter: flip only once the input has differed FILT_LEN cycles
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt  <= 4'd0;
      filt <= 1'b0;
    end else if (booting) begin
      cnt  <= 4'd0;
      filt <= sync2;
    end else if (sync2 == filt) begin
      cnt  <= 4'd0;
    end else if (cnt == FILT_MAX - 4'd1) begin
      cnt  <= FILT_MAX;
      filt <= sync2;
    end else begin
      cnt  <= cnt + 4'd1;
    end
  end
`else
  assign dout = sync2;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns quadrature pins a/b into a direction level u and a
// one-cycle enable strobe, flagging illegal double transitions on err.
// Build option: define QDEC_FILTER_EN to add the FILT_LEN glitch filter.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       a,
  input  logic       b,
  input  logic       err_clr,
  output logic       u,
  output logic       enable,
  output logic       err,
  output logic [1:0] phase
);

  localparam logic [1:0] WARM_LAST = 2'(WARM_CYCLES - 1);

  logic        a_f;
  logic        b_f;
  logic [1:0]  ab;
  logic [1:0]  dir;

  qdec_state_t state;
  qdec_state_t state_next;
  logic [1:0]  warm_cnt;
  logic [1:0]  warm_cnt_next;
  logic        u_next;
  logic        enable_next;
  logic        err_next;
  logic [1:0]  phase_next;

  qdec_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .clr  (clr),
    .din  (a),
    .dout (a_f)
  );

  qdec_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .clr  (clr),
    .din  (b),
    .dout (b_f)
  );

  assign ab = {a_f, b_f};

  // State, phase and output registers; clr aborts any pending step
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= WARM;
      warm_cnt <= 2'd0;
      u        <= 1'b0;
      enable   <= 1'b0;
      err      <= 1'b0;
      phase    <= PH_00;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
      u        <= u_next;
      enable   <= enable_next;
      err      <= err_next;
      phase    <= phase_next;
    end
  end

  // Next-state and output decode: warm up, align to the pins, then track steps
  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    u_next        = u;
    enable_next   = 1'b0;
    err_next      = err & ~err_clr;
    phase_next    = phase;
    dir           = qdec_dir(phase, ab);

    case (state)
      WARM: begin
        if (warm_cnt == WARM_LAST) begin
          state_next = ALIGN;
        end else begin
          warm_cnt_next = warm_cnt + 2'd1;
        end
      end
      ALIGN: begin
        phase_next = ab;
        state_next = TRACK;
      end
      TRACK: begin
        if (ab != phase) begin
          phase_next = ab;
          if (dir[1]) begin
            enable_next = 1'b1;
            u_next      = dir[0];
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = WARM;
      end
    endcase
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: scoreboard bench; stimulus pushes expected step or
// error events, a negedge monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_quad_step_decoder;

  localparam int FILT = 4;
`ifdef QDEC_FILTER_EN
  localparam int LAT      = FILT + 3;
  localparam int MIN_HOLD = FILT;
`else
  localparam int LAT      = 3;
  localparam int MIN_HOLD = 1;
`endif

  typedef struct {
    int cyc;
    bit is_err;
    bit up;
  } ev_t;

  logic       clk     = 1'b0;
  logic       clr     = 1'b0;
  logic       a       = 1'b0;
  logic       b       = 1'b0;
  logic       err_clr = 1'b0;
  logic       u;
  logic       enable;
  logic       err;
  logic [1:0] phase;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  ev_t        exp_q[$];
  logic [1:0] up_seq [4];
  logic [1:0] mab;
  bit         mu;

  quad_step_decoder #(.FILT_LEN(FILT)) dut (
    .clk     (clk),
    .clr     (clr),
    .a       (a),
    .b       (b),
    .err_clr (err_clr),
    .u       (u),
    .enable  (enable),
    .err     (err),
    .phase   (phase)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp expected events
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int gray_pos(input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      if (up_seq[i] == p) return i;
    end
    return 0;
  endfunction

  // Drive new pin levels, predict the resulting event, then hold
  task automatic applyStimulus(input logic [1:0] nab, input int hold);
    ev_t ev;
    int  diff;
    if (nab != mab) begin
      ev.cyc = cyc + LAT;
      if (nab[0] != mab[0] && nab[1] != mab[1]) begin
        ev.is_err = 1'b1;
        ev.up     = mu;
      end else begin
        diff      = (gray_pos(nab) - gray_pos(mab) + 4) % 4;
        ev.is_err = 1'b0;
        ev.up     = (diff == 1);
        mu        = ev.up;
      end
      exp_q.push_back(ev);
    end
    a   = nab[1];
    b   = nab[0];
    mab = nab;
    tick(hold);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    up_seq[0] = 2'b00;
    up_seq[1] = 2'b10;
    up_seq[2] = 2'b11;
    up_seq[3] = 2'b01;
    mab = 2'b11;
    mu  = 1'b0;
    a   = 1'b1;
    b   = 1'b1;

    fork
      begin : stimulus
        ev_t  drop;
        int   choice;
        int   len;
        logic ch;

        clr = 1'b0;
        tick(1);
        checkOutput("rst_enable", 32'(enable), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_u", 32'(u), 32'd0);
        tick(2);
        clr = 1'b1;
        tick(6);
        checkOutput("align_phase", 32'(phase), 32'(2'b11));
        checkOutput("align_err", 32'(err), 32'd0);
        checkOutput("align_u", 32'(u), 32'd0);

        applyStimulus(2'b01, 8);
        applyStimulus(2'b00, 8);

        applyStimulus(2'b10, 8);
        applyStimulus(2'b11, 8);
        applyStimulus(2'b01, 8);
        applyStimulus(2'b00, 8);
        checkOutput("fwd_u_hold", 32'(u), 32'd1);

        applyStimulus(2'b01, 8);
        applyStimulus(2'b11, 8);
        applyStimulus(2'b10, 8);
        applyStimulus(2'b00, 8);
        checkOutput("rev_u_hold", 32'(u), 32'd0);
        checkOutput("rev_phase", 32'(phase), 32'd0);

`ifdef QDEC_FILTER_EN
        a = 1'b1;
        tick(FILT - 1);
        a = 1'b0;
        tick(LAT + 4);
        checkOutput("glitch_phase", 32'(phase), 32'd0);
        checkOutput("glitch_err", 32'(err), 32'd0);
        applyStimulus(2'b10, FILT);
        applyStimulus(2'b00, LAT + 4);
        checkOutput("min_pulse_u", 32'(u), 32'd0);
`endif

        applyStimulus(2'b11, LAT + 4);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_phase", 32'(phase), 32'(2'b11));
        checkOutput("illegal_u_kept", 32'(u), 32'd0);
        pulseErrClr();
        checkOutput("err_cleared", 32'(err), 32'd0);
        tick(1);

        applyStimulus(2'b00, LAT - 1);
        pulseErrClr();
        checkOutput("err_set_wins", 32'(err), 32'd1);
        tick(3);
        pulseErrClr();
        checkOutput("err_cleared_again", 32'(err), 32'd0);

        repeat (300) begin
          choice = $urandom_range(0, 9);
          ch     = 1'($urandom_range(0, 1));
`ifdef QDEC_FILTER_EN
          if (choice < 2) begin
            len = $urandom_range(1, FILT - 1);
            if (ch) a = ~a;
            else    b = ~b;
            tick(len);
            a = mab[1];
            b = mab[0];
            tick(MIN_HOLD);
            continue;
          end
`endif
          applyStimulus(mab ^ (ch ? 2'b10 : 2'b01),
                        $urandom_range(MIN_HOLD, MIN_HOLD + 3));
        end
        tick(LAT + 4);
        checkOutput("random_phase", 32'(phase), 32'(mab));
        checkOutput("random_err", 32'(err), 32'd0);

        for (int i = 0; i < 6; i++) begin
          applyStimulus(mab ^ 2'b10, MIN_HOLD);
        end
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) begin
          drop = exp_q.pop_back();
        end
        clr = 1'b0;
        tick(1);
        checkOutput("midclr_enable", 32'(enable), 32'd0);
        checkOutput("midclr_u", 32'(u), 32'd0);
        checkOutput("midclr_err", 32'(err), 32'd0);
        checkOutput("midclr_phase", 32'(phase), 32'd0);
        mu = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(6);
        checkOutput("realign_phase", 32'(phase), 32'(mab));
        checkOutput("realign_u", 32'(u), 32'd0);

        tick(LAT + 4);
        checkOutput("pending_events", 32'(exp_q.size()), 32'd0);
        while (exp_q.size() > 0) begin
          drop = exp_q.pop_front();
          $display("[TB] missing event at cycle %0d err=%0b up=%0b",
                   drop.cyc, drop.is_err, drop.up);
        end
      end

      begin : monitor
        ev_t  ev;
        logic err_q;
        logic err_rise;
        err_q = 1'b0;
        forever begin
          @(negedge clk);
          err_rise = err && !err_q;
          err_q    = err;
          if (enable || err_rise) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_event: got enable=%0b err_rise=%0b at cycle %0d, expected none",
                       enable, err_rise, cyc);
            end else begin
              ev = exp_q.pop_front();
              checkOutput("event_cycle", 32'(cyc), 32'(ev.cyc));
              checkOutput("event_is_err", 32'(err_rise), 32'(ev.is_err));
              if (!ev.is_err) begin
                checkOutput("step_u", 32'(u), 32'(ev.up));
              end
            end
          end
        end
      end
    join_any

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature input decoder that produces the step/direction command pair consumed by the team's `updown` 4-bit up/down counter. It is the source end of that interface: it turns two-phase encoder signals `a`/`b` into a direction level `u` and a one-cycle `enable` strobe. It synchronizes and glitch-filters the pins, tracks the Gray-coded phase with a state machine, and flags illegal double transitions.

## Interface
- `FILT_LEN`, default 4: consecutive cycles a synchronized input must differ from its filtered value before the filtered value flips. Legal range 1..15.
- `clk` input 1: single system clock, rising edge.
- `clr` input 1: synchronous reset, active-low. Sampled on `clk`.
- `a` input 1: quadrature channel A, asynchronous.
- `b` input 1: quadrature channel B, asynchronous.
- `err_clr` input 1: synchronous clear of `err`, active-high.
- `u` output 1: direction to the counter. 1 = up, 0 = down. Holds the last step direction.
- `enable` output 1: one-cycle step strobe to the counter.
- `err` output 1: sticky illegal-transition flag.
- `phase` output 2: current filtered phase `{A,B}`, for debug.

## Operation
- Input path: two-flop synchronizer per channel, then a per-channel filter (see Configuration).
- FSM states:
  - WARM: entered on reset; counts 2 cycles while the synchronizers fill, then goes to ALIGN.
  - ALIGN: loads the filtered values and `phase` directly from the synchronizer outputs; no step, no error; goes to TRACK next cycle.
  - TRACK: compares the filtered `{A,B}` with `phase` every cycle.
- Up sequence: 00→10→11→01→00 (A leads). Down sequence: the reverse.
- In TRACK, when filtered `{A,B}` differs from `phase`:
  - One-bit change, up order: `enable`=1 and `u`=1 the next cycle; `phase` updates.
  - One-bit change, down order: `enable`=1 and `u`=0 the next cycle; `phase` updates.
  - Both bits changed (illegal): `err` set, `phase` resyncs to the new value, no `enable`, `u` unchanged.
- Decoding is x4: every legal edge of either channel is one step.
- `err` is sticky. `err_clr`=1 clears it. If a new illegal transition and `err_clr` occur in the same cycle, the set wins.
- Reset values: `u`=0, `enable`=0, `err`=0, `phase`=00, FSM=WARM, filter counters=0, synchronizers=0.
- `clr` asserted mid-operation aborts everything on that edge, including any pending step. No `enable` is emitted during WARM or ALIGN.

## Timing
- Latency, filter compiled in: `enable` is high after the (FILT_LEN+3)th rising `clk` edge that samples the new level.
- Latency, filter compiled out: after the 3rd edge.
- `enable` is exactly one cycle wide. `u` is valid in the same cycle as `enable` and stays stable afterward.
- Maximum step rate: one step per cycle without the filter. With the filter, each channel level must be stable ≥ FILT_LEN cycles.
- A glitch shorter than FILT_LEN cycles produces no step and no error.
- Filter counter: reset to 0 whenever the synchronized value equals the filtered value. It saturates at FILT_LEN, and the filtered value flips on the same edge the counter reaches FILT_LEN.
- If A and B both flip on the same filtered edge, that is an illegal transition, even if the pin edges were cycles apart but landed in the same filter window.

## Configuration
- Macro: `QDEC_FILTER_EN`.
- Defined: the per-channel glitch filter is instantiated with `FILT_LEN`. Latency is FILT_LEN+3.
- Undefined: filtered value = synchronized value. `FILT_LEN` is ignored. Latency is 3.
- Ports and FSM are identical in both builds.

## Structure
- Shared package `qdec_pkg` holds:
  - FSM state encoding (WARM, ALIGN, TRACK).
  - Phase constants PH_00, PH_10, PH_11, PH_01.
  - Function `qdec_dir(old, new)` returning {legal, up}.
- Sub-module `qdec_chan_filter`: one instance per channel, containing the 2-flop synchronizer plus the `QDEC_FILTER_EN`-guarded filter counter. Its ports are `clk`, `clr`, `din`, `dout`.
- The top level holds the FSM, phase register, and output registers.

## Test plan
Benches run with FILT_LEN=4 and the filter enabled unless stated otherwise.
- Reset: hold `clr`=0 for 3 cycles with `a`=`b`=1, then release → `enable` stays 0, `err`=0, `phase`=11 after ALIGN, `u`=0.
- Forward rotation: from 00, drive a=1, then b=1, then a=0, then b=0, each held 8 cycles → 4 `enable` pulses with `u`=1. Each pulse lands 7 edges after its pin change.
- Reverse rotation: from 00, drive b=1, a=1, b=0, a=0 → 4 pulses with `u`=0. `u` goes to 0 with the first pulse and holds.
- Glitch: a 3-cycle high pulse on `a` → no `enable`, no `err`. A 4-cycle pulse → up step, then down step.
- Illegal transition: from 00, drive `a` and `b` high on the same cycle → `err`=1, `phase`=11, no `enable`. Then `err_clr`=1 for 1 cycle → `err`=0.
- Filter compiled out: toggle `a` every cycle from phase 00 → `enable` every cycle, with `u` alternating 1,0 and latency 3. Then assert `clr` mid-stream → outputs return to reset values on that edge.
